// File: rtl/moter_controller.sv
// Turntable/fan motor driver: turns run/defrost level requests into an H-bridge
// command plus a fixed-frequency PWM enable, with a timed brake on every stop.
module moter_controller #(
  parameter int unsigned PWM_PERIOD   = 32'd1000,
  parameter int unsigned RUN_DUTY     = 32'd700,
  parameter int unsigned DEFROST_DUTY = 32'd300,
  parameter int unsigned BRAKE_CYCLES = 32'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       defrost_start,
  output logic [1:0] moter_control,
  output logic       pwm_out
);

  localparam int CNT_W = (PWM_PERIOD > 32'd1) ? $clog2(PWM_PERIOD) : 1;
  localparam int BRK_W = (BRAKE_CYCLES > 32'd1) ? $clog2(BRAKE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 32'd1);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRAKE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_DEFROST = 2'b10,
    S_BRAKE   = 2'b11
  } t_state;

  t_state             r_state;
  t_state             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BRK_W-1:0]   r_brk;
  logic [BRK_W-1:0]   w_brk_nxt;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_brk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_brk   <= w_brk_nxt;
    end
  end

  // Next-state selection; start outranks defrost_start, BRAKE ignores requests
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else if (defrost_start) begin
          w_state_nxt = S_DEFROST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN, S_DEFROST: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else if (defrost_start) begin
          w_state_nxt = S_DEFROST;
        end else begin
          w_state_nxt = S_BRAKE;
        end
      end
      S_BRAKE: begin
        if (r_brk == BRK_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BRAKE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PWM phase restarts on any entry to a drive state, including RUN<->DEFROST
  always_comb begin
    w_cnt_nxt = '0;
    if ((w_state_nxt == S_RUN || w_state_nxt == S_DEFROST) && (w_state_nxt == r_state)) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // Brake timer counts only while staying in BRAKE
  always_comb begin
    w_brk_nxt = '0;
    if (r_state == S_BRAKE && w_state_nxt == S_BRAKE) begin
      w_brk_nxt = r_brk + {{(BRK_W-1){1'b0}}, 1'b1};
    end else begin
      w_brk_nxt = '0;
    end
  end

  // Output decode from registers only
  always_comb begin
    moter_control = 2'b00;
    pwm_out       = 1'b0;
    case (r_state)
      S_IDLE: begin
        moter_control = 2'b00;
        pwm_out       = 1'b0;
      end
      S_RUN: begin
        moter_control = 2'b10;
        pwm_out       = (32'(r_cnt) < RUN_DUTY);
      end
      S_DEFROST: begin
        moter_control = 2'b10;
        pwm_out       = (32'(r_cnt) < DEFROST_DUTY);
      end
      S_BRAKE: begin
        moter_control = 2'b11;
        pwm_out       = 1'b0;
      end
      default: begin
        moter_control = 2'b00;
        pwm_out       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_moter_controller.sv
// Self-checking bench for moter_controller: directed plan plus random request
// segments, checked every cycle against a mode/elapsed-time reference model.
module tb_moter_controller;

  localparam int PERIOD  = 1000;
  localparam int RDUTY   = 700;
  localparam int DDUTY   = 300;
  localparam int BRAKE_N = 100;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DEF   = 2;
  localparam int M_BRAKE = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       defrost_start;
  logic [1:0] moter_control;
  logic       pwm_out;

  int n_err;
  int n_chk;
  int m_mode;
  int m_el;
  int hi_cnt;
  int brk_cnt;

  moter_controller #(
    .PWM_PERIOD  (PERIOD),
    .RUN_DUTY    (RDUTY),
    .DEFROST_DUTY(DDUTY),
    .BRAKE_CYCLES(BRAKE_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .defrost_start(defrost_start),
    .moter_control(moter_control),
    .pwm_out      (pwm_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp_v);
    end
  endtask

  // One clock: apply inputs, advance the model with what the edge sampled, compare.
  task automatic step(input logic s, input logic d, input logic r);
    int nxt;
    logic [1:0] exp_mc;
    logic       exp_pwm;
    start         = s;
    defrost_start = d;
    rst           = r;
    @(posedge clk);
    if (r) begin
      m_mode = M_IDLE;
      m_el   = 0;
    end else begin
      if (m_mode == M_BRAKE)
        nxt = (m_el >= BRAKE_N - 1) ? M_IDLE : M_BRAKE;
      else if (s)
        nxt = M_RUN;
      else if (d)
        nxt = M_DEF;
      else
        nxt = (m_mode == M_IDLE) ? M_IDLE : M_BRAKE;
      m_el   = (nxt == m_mode) ? m_el + 1 : 0;
      m_mode = nxt;
    end
    #1;
    case (m_mode)
      M_RUN:   begin exp_mc = 2'b10; exp_pwm = ((m_el % PERIOD) < RDUTY); end
      M_DEF:   begin exp_mc = 2'b10; exp_pwm = ((m_el % PERIOD) < DDUTY); end
      M_BRAKE: begin exp_mc = 2'b11; exp_pwm = 1'b0; end
      default: begin exp_mc = 2'b00; exp_pwm = 1'b0; end
    endcase
    check_val("moter_control", 32'(moter_control), 32'(exp_mc));
    check_val("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    if (pwm_out === 1'b1) hi_cnt++;
    if (moter_control === 2'b11) brk_cnt++;
  endtask

  task automatic hold(input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) step(s, d, 1'b0);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    m_mode = M_IDLE;
    m_el = 0;
    rst = 1'b1;
    start = 1'b0;
    defrost_start = 1'b0;

    // reset held with start high, then first edge after release enters RUN
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    hi_cnt = 0;
    hold(1'b1, 1'b0, 10000);
    check_val("run_high_total", 32'(hi_cnt), 32'(10 * RDUTY));

    brk_cnt = 0;
    hold(1'b0, 1'b0, 150);
    check_val("brake_len_run", 32'(brk_cnt), 32'(BRAKE_N));

    hi_cnt = 0;
    hold(1'b0, 1'b1, 10000);
    check_val("defrost_high_total", 32'(hi_cnt), 32'(10 * DDUTY));
    brk_cnt = 0;
    hold(1'b0, 1'b0, 150);
    check_val("brake_len_defrost", 32'(brk_cnt), 32'(BRAKE_N));

    // both requests -> RUN, then drop start mid-high-phase -> DEFROST
    hold(1'b1, 1'b1, 450);
    hold(1'b0, 1'b1, 1200);
    hold(1'b1, 1'b0, 1500);

    // stop, raise defrost at brake cycle 50
    hold(1'b0, 1'b0, 50);
    hold(1'b0, 1'b1, 400);
    hold(1'b0, 1'b0, 120);

    // reset in the middle of a run and in the middle of a brake
    hold(1'b1, 1'b0, 300);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 200);
    hold(1'b0, 1'b0, 30);
    step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 1'b1, 40);

    // random request segments
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      logic s;
      logic d;
      s = 1'($urandom_range(1, 0));
      d = 1'($urandom_range(1, 0));
      len = int'($urandom_range(1200, 1));
      if ($urandom_range(15, 0) == 0)
        step(s, d, 1'b1);
      hold(s, d, len);
    end
    hold(1'b0, 1'b0, 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
